sec_alarm_timer: RTL and testbench



---
 rtl/sec_alarm_pkg.sv | 12 +
 rtl/sec_prescaler.sv | 45 ++++
 rtl/sec_alarm_timer.sv | 162 ++++++++++++++++
 tb/tb_sec_alarm_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sec_alarm_pkg.sv
// Shared types and constants for the seconds alarm timer.
package sec_alarm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle strobe every CLK_HZ enabled cycles.
module sec_prescaler #(
  parameter int CLK_HZ = 32768
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_pre
);

  localparam int PRE_W = $clog2(CLK_HZ);
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  // Next count and wrap strobe; a clear masks the strobe so restarts suppress it.
  always_comb begin
    pre_d    = pre_q;
    tick_pre = 1'b0;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == PRE_TC) begin
        pre_d    = '0;
        tick_pre = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/sec_alarm_timer.sv
// Seconds timer with one-shot/periodic alarm interrupt.
// Optional sticky interrupt flag enabled by defining SEC_ALARM_STICKY_EN.
module sec_alarm_timer
  import sec_alarm_pkg::*;
#(
  parameter int CLK_HZ = 32768,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] alarm,
  output logic [CNT_W-1:0] sec_cnt,
  output logic             busy,
  output logic             tick,
  output logic             int_pulse
`ifdef SEC_ALARM_STICKY_EN
  ,
  input  logic             irq_clr,
  output logic             irq_flag
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sec_q, sec_d;
  logic [CNT_W-1:0] alarm_q, alarm_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             int_q, int_d;
  logic             tick_pre;
  logic [CNT_W-1:0] sec_inc;

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == ST_RUN),
    .clr      (start | stop),
    .tick_pre (tick_pre)
  );

  assign sec_inc = sec_q + CNT_W'(1);

  // Next-state, counter and pulse logic; stop outranks start, start outranks a wrap.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    alarm_d = alarm_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    int_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          if (alarm != '0) begin
            alarm_d = alarm;
            mode_d  = mode;
            sec_d   = '0;
            state_d = ST_RUN;
          end else begin
            int_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          sec_d   = '0;
          state_d = ST_IDLE;
        end else if (start) begin
          sec_d = '0;
          if (alarm != '0) begin
            alarm_d = alarm;
            mode_d  = mode;
          end else begin
            int_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tick_pre) begin
          tick_d = 1'b1;
          if (sec_inc == alarm_q) begin
            sec_d = '0;
            int_d = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            sec_d = sec_inc;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        sec_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      alarm_q <= '0;
      mode_q  <= MODE_ONESHOT;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      alarm_q <= alarm_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      int_q   <= int_d;
    end
  end

  assign sec_cnt   = sec_q;
  assign busy      = busy_q;
  assign tick      = tick_q;
  assign int_pulse = int_q;

`ifdef SEC_ALARM_STICKY_EN
  logic flag_q, flag_d;

  // Sticky flag follows the visible pulse; a set beats a coincident clear.
  always_comb begin
    flag_d = flag_q;
    if (int_q) begin
      flag_d = 1'b1;
    end else if (irq_clr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign irq_flag = flag_q;
`endif

endmodule

// File: tb/tb_sec_alarm_timer.sv
// Scoreboard bench for sec_alarm_timer with CLK_HZ=4: expected tick/int events are
// queued when stimulus is issued and a negedge monitor checks them cycle-exactly.
module tb_sec_alarm_timer;

  localparam int CLK_HZ = 4;
  localparam int CNT_W  = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             mode;
  logic [CNT_W-1:0] alarm;
  logic [CNT_W-1:0] sec_cnt;
  logic             busy;
  logic             tick;
  logic             int_pulse;
`ifdef SEC_ALARM_STICKY_EN
  logic             irq_clr;
  logic             irq_flag;
`endif

  sec_alarm_timer #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .alarm     (alarm),
    .sec_cnt   (sec_cnt),
    .busy      (busy),
    .tick      (tick),
    .int_pulse (int_pulse)
`ifdef SEC_ALARM_STICKY_EN
    ,
    .irq_clr   (irq_clr),
    .irq_flag  (irq_flag)
`endif
  );

  typedef struct {
    int unsigned      at;
    logic             tk;
    logic             irq;
    logic [CNT_W-1:0] sec;
    logic             bsy;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned edge_n;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, req);
    end
  endtask

  task automatic expect_ev(input int unsigned at, input logic tk, input logic irq,
                           input logic [CNT_W-1:0] sec, input logic bsy);
    ev_t e;
    e.at = at; e.tk = tk; e.irq = irq; e.sec = sec; e.bsy = bsy;
    exp_q.push_back(e);
  endtask

  // Drive one-cycle control pulse so it is sampled at edge tgt; returns at the negedge after tgt.
  task automatic drive_at(input int unsigned tgt, input logic st, input logic sp,
                          input logic [CNT_W-1:0] al, input logic md);
    while (edge_n + 1 < tgt) @(negedge clk);
    start = st; stop = sp; alarm = al; mode = md;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: scheduled events are compared field by field, any other pulse is unexpected.
  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
      ev_t e;
      e = exp_q.pop_front();
      chk("tick", 32'(tick), 32'(e.tk));
      chk("int_pulse", 32'(int_pulse), 32'(e.irq));
      chk("sec_cnt", 32'(sec_cnt), 32'(e.sec));
      chk("busy", 32'(busy), 32'(e.bsy));
    end else if (tick || int_pulse) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pulse at edge %0d: tick=%0b int=%0b, expected none",
               edge_n, tick, int_pulse);
    end
  end

  initial begin
    int unsigned s;
    int unsigned r;
    edge_n = 0; n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; alarm = '0;
`ifdef SEC_ALARM_STICKY_EN
    irq_clr = 1'b0;
`endif
    idle_cycles(3);
    chk("rst_sec_cnt", 32'(sec_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_int", 32'(int_pulse), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // One-shot, alarm=3.
    s = edge_n + 1;
    expect_ev(s + 4, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_ev(s + 8, 1'b1, 1'b0, 8'd2, 1'b1);
    expect_ev(s + 12, 1'b1, 1'b1, 8'd0, 1'b0);
    drive_at(s, 1'b1, 1'b0, 8'd3, 1'b0);
    chk("oneshot_busy_rise", 32'(busy), 32'd1);
    alarm = 8'd1; mode = 1'b1;
    idle_cycles(12 + 40);

    // Periodic, alarm=2, then stop.
    s = edge_n + 1;
    for (int k = 1; k <= 6; k++)
      expect_ev(s + 4 * k, 1'b1, (k % 2) == 0, ((k % 2) == 0) ? 8'd0 : 8'd1, 1'b1);
    drive_at(s, 1'b1, 1'b0, 8'd2, 1'b1);
    drive_at(s + 26, 1'b0, 1'b1, 8'd0, 1'b0);
    chk("periodic_stop_busy", 32'(busy), 32'd0);
    idle_cycles(20);

    // alarm=5, stop at S+9, then restart with alarm=1.
    s = edge_n + 1;
    expect_ev(s + 4, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_ev(s + 8, 1'b1, 1'b0, 8'd2, 1'b1);
    drive_at(s, 1'b1, 1'b0, 8'd5, 1'b0);
    drive_at(s + 9, 1'b0, 1'b1, 8'd5, 1'b0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_sec_cnt", 32'(sec_cnt), 32'd0);
    idle_cycles(40);
    r = edge_n + 1;
    expect_ev(r + 4, 1'b1, 1'b1, 8'd0, 1'b0);
    drive_at(r, 1'b1, 1'b0, 8'd1, 1'b0);
    idle_cycles(10);

    // alarm=0 start: immediate pulse, stays idle.
    s = edge_n + 1;
    expect_ev(s, 1'b0, 1'b1, 8'd0, 1'b0);
    drive_at(s, 1'b1, 1'b0, 8'd0, 1'b0);
`ifdef SEC_ALARM_STICKY_EN
    irq_clr = 1'b1;
    @(negedge clk);
    chk("flag_set_beats_clr", 32'(irq_flag), 32'd1);
    @(negedge clk);
    chk("flag_cleared", 32'(irq_flag), 32'd0);
    irq_clr = 1'b0;
    s = edge_n + 1;
    expect_ev(s, 1'b0, 1'b1, 8'd0, 1'b0);
    drive_at(s, 1'b1, 1'b0, 8'd0, 1'b0);
    idle_cycles(3);
    chk("flag_held", 32'(irq_flag), 32'd1);
`endif
    idle_cycles(5);
    chk("alarm0_busy", 32'(busy), 32'd0);

    // Start and stop together from idle: ignored.
    drive_at(edge_n + 1, 1'b1, 1'b1, 8'd3, 1'b0);
    chk("startstop_busy", 32'(busy), 32'd0);
    idle_cycles(20);

    // Restart at S+11 suppresses the S+12 alarm.
    s = edge_n + 1;
    r = s + 11;
    expect_ev(s + 4, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_ev(s + 8, 1'b1, 1'b0, 8'd2, 1'b1);
    expect_ev(r + 4, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_ev(r + 8, 1'b1, 1'b0, 8'd2, 1'b1);
    expect_ev(r + 12, 1'b1, 1'b1, 8'd0, 1'b0);
    drive_at(s, 1'b1, 1'b0, 8'd3, 1'b0);
    drive_at(r, 1'b1, 1'b0, 8'd3, 1'b0);
    chk("restart_sec_cnt", 32'(sec_cnt), 32'd0);
    idle_cycles(20);

    // Asynchronous reset mid periodic run.
    s = edge_n + 1;
    expect_ev(s + 4, 1'b1, 1'b0, 8'd1, 1'b1);
    drive_at(s, 1'b1, 1'b0, 8'd2, 1'b1);
    while (edge_n < s + 6) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_sec_cnt", 32'(sec_cnt), 32'd0);
    chk("async_rst_pulses", 32'({tick, int_pulse}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(20);
    chk("post_reset_busy", 32'(busy), 32'd0);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_event: expected at edge %0d, still pending at edge %0d", e.at, edge_n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
